// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared AXI response/burst constants, arbiter state type and index-width helper.
package axi_arb_pkg;
    localparam logic [1:0] OKAY = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] BURST_WRAP = 2'b10;
    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/axi_arb_route_fifo.sv
// axi_arb_route_fifo: synchronous FIFO holding owner indices of outstanding transactions.
module axi_arb_route_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic [PW:0] cnt;
    logic do_push, do_pop;
    assign full = cnt == (PW + 1)'(DEPTH);
    assign empty = cnt == '0;
    // a full FIFO refuses a push even when it pops in the same cycle
    assign do_push = push & ~full;
    assign do_pop = pop & ~empty;
    assign head = mem[rp];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
            cnt <= cnt + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
endmodule

// File: rtl/axi_rr_arb_mo.sv
// axi_rr_arb_mo: N:1 AXI arbiter, independent round-robin AW/AR with in-order owner FIFOs.
// Define AXI_ARB_PRIO_EN to give master 0 strict priority on AW and AR.
module axi_rr_arb_mo
    import axi_arb_pkg::*;
#(
    parameter int N = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 24,
    parameter int STRB_WIDTH = 4,
    parameter int ID_WIDTH = 4,
    parameter int OT_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N-1:0]               m_awvalid,
    output logic [N-1:0]               m_awready,
    input  logic [N*ADDR_WIDTH-1:0]    m_awaddr,
    input  logic [N*ID_WIDTH-1:0]      m_awid,
    input  logic [N*8-1:0]             m_awlen,
    input  logic [N*3-1:0]             m_awsize,
    input  logic [N*2-1:0]             m_awburst,
    input  logic [N-1:0]               m_wvalid,
    output logic [N-1:0]               m_wready,
    input  logic [N*DATA_WIDTH-1:0]    m_wdata,
    input  logic [N*STRB_WIDTH-1:0]    m_wstrb,
    input  logic [N-1:0]               m_wlast,
    output logic [N-1:0]               m_bvalid,
    input  logic [N-1:0]               m_bready,
    output logic [N*2-1:0]             m_bresp,
    output logic [N*ID_WIDTH-1:0]      m_bid,
    input  logic [N-1:0]               m_arvalid,
    output logic [N-1:0]               m_arready,
    input  logic [N*ADDR_WIDTH-1:0]    m_araddr,
    input  logic [N*ID_WIDTH-1:0]      m_arid,
    input  logic [N*8-1:0]             m_arlen,
    input  logic [N*3-1:0]             m_arsize,
    input  logic [N*2-1:0]             m_arburst,
    output logic [N-1:0]               m_rvalid,
    input  logic [N-1:0]               m_rready,
    output logic [N*DATA_WIDTH-1:0]    m_rdata,
    output logic [N*2-1:0]             m_rresp,
    output logic [N-1:0]               m_rlast,
    output logic [N*ID_WIDTH-1:0]      m_rid,
    output logic                       s_awvalid,
    input  logic                       s_awready,
    output logic [ADDR_WIDTH-1:0]      s_awaddr,
    output logic [ID_WIDTH-1:0]        s_awid,
    output logic [7:0]                 s_awlen,
    output logic [2:0]                 s_awsize,
    output logic [1:0]                 s_awburst,
    output logic                       s_wvalid,
    input  logic                       s_wready,
    output logic [DATA_WIDTH-1:0]      s_wdata,
    output logic [STRB_WIDTH-1:0]      s_wstrb,
    output logic                       s_wlast,
    input  logic                       s_bvalid,
    output logic                       s_bready,
    input  logic [1:0]                 s_bresp,
    input  logic [ID_WIDTH-1:0]        s_bid,
    output logic                       s_arvalid,
    input  logic                       s_arready,
    output logic [ADDR_WIDTH-1:0]      s_araddr,
    output logic [ID_WIDTH-1:0]        s_arid,
    output logic [7:0]                 s_arlen,
    output logic [2:0]                 s_arsize,
    output logic [1:0]                 s_arburst,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    input  logic [DATA_WIDTH-1:0]      s_rdata,
    input  logic [1:0]                 s_rresp,
    input  logic                       s_rlast,
    input  logic [ID_WIDTH-1:0]        s_rid
);
    localparam int IDX_W = idx_w(N);
`ifdef AXI_ARB_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif
    logic [1:0][N-1:0] req;
    logic [1:0][IDX_W-1:0] win;
    logic [1:0] sv, hs, sr, ok;
    logic wf_full, wf_empty, bf_full, bf_empty, rf_full, rf_empty;
    logic [IDX_W-1:0] wh, bh, rh;
    logic w_act, b_own, r_own;
    assign req = {m_arvalid, m_awvalid};
    assign sr = {s_arready, s_awready};
    // rst gating keeps every master-facing ready low while reset is held
    assign ok = {~rst & ~rf_full, ~rst & ~wf_full & ~bf_full};
    // index 0 arbitrates AW, index 1 arbitrates AR
    for (genvar d = 0; d < 2; d++) begin : g_arb
        arb_state_e state_q, state_d;
        logic [IDX_W-1:0] ptr, lock, pick, j;
        logic found;
        always_comb begin
            found = 1'b0;
            pick = ptr;
            j = '0;
            if (PRIO && req[d][0]) begin
                found = 1'b1;
                pick = '0;
            end
            for (int k = 0; k < N; k++) begin
                j = IDX_W'((int'(ptr) + k) % N);
                if (!found && req[d][j]) begin
                    found = 1'b1;
                    pick = j;
                end
            end
        end
        assign win[d] = (state_q == ARB_LOCKED) ? lock : pick;
        assign sv[d] = ok[d] & ((state_q == ARB_LOCKED) ? req[d][lock] : found);
        assign hs[d] = sv[d] & sr[d];
        always_comb begin
            state_d = state_q;
            if (hs[d]) state_d = ARB_IDLE;
            else if (sv[d]) state_d = ARB_LOCKED;
        end
        always_ff @(posedge clk or posedge rst)
            if (rst) begin
                state_q <= ARB_IDLE;
                ptr <= '0;
                lock <= '0;
            end else begin
                state_q <= state_d;
                if (state_q == ARB_IDLE) lock <= pick;
                if (hs[d] && !(PRIO && win[d] == '0))
                    ptr <= (int'(win[d]) == N - 1) ? '0 : win[d] + 1'b1;
            end
    end
    axi_arb_route_fifo #(.WIDTH(IDX_W), .DEPTH(OT_DEPTH)) u_wf (
        .clk(clk), .rst(rst), .push(hs[0]), .pop(s_wvalid & s_wready & s_wlast),
        .din(win[0]), .full(wf_full), .empty(wf_empty), .head(wh));
    axi_arb_route_fifo #(.WIDTH(IDX_W), .DEPTH(OT_DEPTH)) u_bf (
        .clk(clk), .rst(rst), .push(hs[0]), .pop(s_bvalid & s_bready),
        .din(win[0]), .full(bf_full), .empty(bf_empty), .head(bh));
    axi_arb_route_fifo #(.WIDTH(IDX_W), .DEPTH(OT_DEPTH)) u_rf (
        .clk(clk), .rst(rst), .push(hs[1]), .pop(s_rvalid & s_rready & s_rlast),
        .din(win[1]), .full(rf_full), .empty(rf_empty), .head(rh));
    assign s_awvalid = sv[0];
    assign s_awaddr = sv[0] ? m_awaddr[win[0]*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_awid = sv[0] ? m_awid[win[0]*ID_WIDTH +: ID_WIDTH] : '0;
    assign s_awlen = sv[0] ? m_awlen[win[0]*8 +: 8] : '0;
    assign s_awsize = sv[0] ? m_awsize[win[0]*3 +: 3] : '0;
    assign s_awburst = sv[0] ? m_awburst[win[0]*2 +: 2] : '0;
    assign m_awready = sv[0] ? N'(s_awready) << win[0] : '0;
    assign s_arvalid = sv[1];
    assign s_araddr = sv[1] ? m_araddr[win[1]*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign s_arid = sv[1] ? m_arid[win[1]*ID_WIDTH +: ID_WIDTH] : '0;
    assign s_arlen = sv[1] ? m_arlen[win[1]*8 +: 8] : '0;
    assign s_arsize = sv[1] ? m_arsize[win[1]*3 +: 3] : '0;
    assign s_arburst = sv[1] ? m_arburst[win[1]*2 +: 2] : '0;
    assign m_arready = sv[1] ? N'(s_arready) << win[1] : '0;
    assign w_act = ~wf_empty & m_wvalid[wh];
    assign s_wvalid = w_act;
    assign s_wdata = w_act ? m_wdata[wh*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign s_wstrb = w_act ? m_wstrb[wh*STRB_WIDTH +: STRB_WIDTH] : '0;
    assign s_wlast = w_act & m_wlast[wh];
    assign m_wready = wf_empty ? '0 : N'(s_wready) << wh;
    assign b_own = ~bf_empty & s_bvalid;
    assign r_own = ~rf_empty & s_rvalid;
    assign s_bready = ~bf_empty & m_bready[bh];
    assign s_rready = ~rf_empty & m_rready[rh];
    assign m_bvalid = b_own ? N'(1) << bh : '0;
    assign m_rvalid = r_own ? N'(1) << rh : '0;
    always_comb begin
        m_bresp = '0;
        m_bid = '0;
        m_rdata = '0;
        m_rresp = '0;
        m_rlast = '0;
        m_rid = '0;
        if (b_own) begin
            m_bresp[bh*2 +: 2] = s_bresp;
            m_bid[bh*ID_WIDTH +: ID_WIDTH] = s_bid;
        end
        if (r_own) begin
            m_rdata[rh*DATA_WIDTH +: DATA_WIDTH] = s_rdata;
            m_rresp[rh*2 +: 2] = s_rresp;
            m_rlast[rh] = s_rlast;
            m_rid[rh*ID_WIDTH +: ID_WIDTH] = s_rid;
        end
    end
endmodule

// File: tb/tb_axi_rr_arb_mo.sv
// tb_axi_rr_arb_mo: directed self-checking bench for axi_rr_arb_mo.
module tb_axi_rr_arb_mo;
    import axi_arb_pkg::*;
    localparam int N = 8, AW = 16, DW = 24, SW = 4, IW = 4, OT = 4;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [N-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [N*AW-1:0] m_awaddr, m_araddr;
    logic [N*IW-1:0] m_awid, m_arid, m_bid, m_rid;
    logic [N*8-1:0] m_awlen, m_arlen;
    logic [N*3-1:0] m_awsize, m_arsize;
    logic [N*2-1:0] m_awburst, m_arburst, m_bresp, m_rresp;
    logic [N*DW-1:0] m_wdata, m_rdata;
    logic [N*SW-1:0] m_wstrb;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
    logic [AW-1:0] s_awaddr, s_araddr;
    logic [IW-1:0] s_awid, s_arid, s_bid, s_rid;
    logic [7:0] s_awlen, s_arlen;
    logic [2:0] s_awsize, s_arsize;
    logic [1:0] s_awburst, s_arburst, s_bresp, s_rresp;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [SW-1:0] s_wstrb;
    int checks = 0, errors = 0;

    axi_rr_arb_mo #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW),
                    .ID_WIDTH(IW), .OT_DEPTH(OT)) dut (
        .clk(clk), .rst(rst),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_rlast(m_rlast), .m_rid(m_rid),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp), .s_bid(s_bid),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rlast(s_rlast), .s_rid(s_rid)
    );

    task automatic idle();
        m_awvalid = '0; m_wvalid = '0; m_wlast = '0; m_wdata = '0; m_bready = '0;
        m_arvalid = '0; m_rready = '0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = OKAY; s_bid = '0;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = OKAY; s_rlast = 0; s_rid = '0;
    endtask

    task automatic test_reset();
        idle();
        m_awvalid = '1; m_arvalid = '1; m_wvalid = '1; s_bvalid = 1; s_rvalid = 1;
        s_awready = 1; s_arready = 1; m_bready = '1; m_rready = '1;
        #12;
        checks++;
        if ({s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready} !== 5'b0) begin
            errors++; $display("FAIL reset_s_ctrl: got %b, expected 00000",
                               {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready});
        end
        checks++;
        if ({m_awready, m_wready, m_bvalid, m_arready, m_rvalid} !== '0) begin
            errors++; $display("FAIL reset_m_ctrl: got %h, expected 0",
                               {m_awready, m_wready, m_bvalid, m_arready, m_rvalid});
        end
        checks++;
        if ({s_awaddr, s_araddr, s_wdata} !== '0 || m_rdata !== '0 || m_bresp !== '0) begin
            errors++; $display("FAIL reset_payload: awaddr=%h araddr=%h wdata=%h, expected 0",
                               s_awaddr, s_araddr, s_wdata);
        end
        @(posedge clk); #1;
        idle();
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_ar_rr();
        int om [3];
        logic [N*DW-1:0] ed;
        om = '{2, 5, 6};
        s_arready = 1;
        m_arvalid = 8'b0110_0100;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (m_arready !== N'(1) << om[k] || s_araddr !== AW'(16'h2000 + om[k])) begin
                errors++; $display("FAIL ar_grant[%0d]: m_arready=%b araddr=%h, expected master %0d",
                                   k, m_arready, s_araddr, om[k]);
            end
            @(posedge clk); #1;
            m_arvalid[om[k]] = 1'b0;
        end
        s_arready = 0;
        m_rready = '1;
        for (int k = 0; k < 6; k++) begin
            s_rvalid = 1; s_rlast = (k % 2 == 1); s_rdata = DW'(24'hA00000 + k); s_rid = IW'(k);
            ed = '0;
            ed[om[k/2]*DW +: DW] = DW'(24'hA00000 + k);
            #1;
            checks++;
            if (m_rvalid !== N'(1) << om[k/2] || m_rdata !== ed || s_rready !== 1'b1) begin
                errors++; $display("FAIL r_route[%0d]: m_rvalid=%b s_rready=%b, expected owner %0d",
                                   k, m_rvalid, s_rready, om[k/2]);
            end
            @(posedge clk); #1;
        end
        #1;
        checks++;
        if (s_rready !== 1'b0 || m_rvalid !== '0) begin
            errors++; $display("FAIL r_stray: s_rready=%b m_rvalid=%b, expected 0 0", s_rready, m_rvalid);
        end
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_aw_lock();
        logic [N*IW-1:0] eb;
        int om [2];
        om = '{3, 1};
        m_awvalid = 8'b0000_1000;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) m_awvalid[1] = 1'b1;
            if (c == 3) s_awready = 1;
            #1;
            checks++;
            if (s_awaddr !== 16'h1003 || m_awready !== ((c == 3) ? 8'b0000_1000 : 8'b0)) begin
                errors++; $display("FAIL aw_lock[%0d]: awaddr=%h m_awready=%b, expected 1003",
                                   c, s_awaddr, m_awready);
            end
            @(posedge clk); #1;
        end
        m_awvalid[3] = 1'b0;
        #1;
        checks++;
        if (s_awaddr !== 16'h1001 || m_awready !== 8'b0000_0010) begin
            errors++; $display("FAIL aw_next: awaddr=%h m_awready=%b, expected 1001 00000010",
                               s_awaddr, m_awready);
        end
        @(posedge clk); #1;
        idle();
        m_wvalid = 8'b0000_1010; m_wlast = '1; s_wready = 1;
        m_wdata[3*DW +: DW] = 24'h333333; m_wdata[1*DW +: DW] = 24'h111111;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (m_wready !== N'(1) << om[k] || s_wdata !== DW'(om[k] * 24'h111111) || s_wlast !== 1'b1) begin
                errors++; $display("FAIL w_order[%0d]: m_wready=%b wdata=%h, expected master %0d",
                                   k, m_wready, s_wdata, om[k]);
            end
            @(posedge clk); #1;
            m_wvalid[om[k]] = 1'b0;
        end
        idle();
        m_bready = '1; s_bvalid = 1; s_bresp = SLVERR; s_bid = 4'h9;
        for (int k = 0; k < 2; k++) begin
            eb = '0;
            eb[om[k]*IW +: IW] = 4'h9;
            #1;
            checks++;
            if (m_bvalid !== N'(1) << om[k] || m_bid !== eb || m_bresp[om[k]*2 +: 2] !== SLVERR) begin
                errors++; $display("FAIL b_order[%0d]: m_bvalid=%b m_bid=%h, expected master %0d",
                                   k, m_bvalid, m_bid, om[k]);
            end
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_ot_limit();
        int bc [4];
        logic [N-1:0] wr;
        logic [N*IW-1:0] eb;
        s_awready = 1;
        for (int i = 0; i < 4; i++) begin
            m_awvalid = N'(1) << i;
            #1;
            checks++;
            if (m_awready !== N'(1) << i || s_awlen !== 8'd3) begin
                errors++; $display("FAIL ot_grant[%0d]: m_awready=%b awlen=%0d, expected master %0d len 3",
                                   i, m_awready, s_awlen, i);
            end
            @(posedge clk); #1;
        end
        m_awvalid = 8'b0001_0000;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (s_awvalid !== 1'b0 || m_awready !== '0) begin
                errors++; $display("FAIL ot_block[%0d]: s_awvalid=%b m_awready=%b, expected 0",
                                   c, s_awvalid, m_awready);
            end
            @(posedge clk); #1;
        end
        bc = '{default: 0};
        m_wvalid = 8'h0F; s_wready = 1;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 4; i++) begin
                m_wdata[i*DW +: DW] = DW'(i * 16 + bc[i]);
                m_wlast[i] = (bc[i] == 3);
            end
            #1;
            checks++;
            if (s_wdata !== DW'((k / 4) * 16 + k % 4) || s_wlast !== (k % 4 == 3) ||
                m_wready !== N'(1) << (k / 4)) begin
                errors++; $display("FAIL ot_wbeat[%0d]: wdata=%h wlast=%b m_wready=%b, expected master %0d beat %0d",
                                   k, s_wdata, s_wlast, m_wready, k / 4, k % 4);
            end
            wr = m_wready;
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) if (wr[i]) bc[i]++;
        end
        m_wvalid = '0; m_wlast = '0;
        #1;
        checks++;
        if (s_awvalid !== 1'b0 || s_wvalid !== 1'b0) begin
            errors++; $display("FAIL ot_bfull: s_awvalid=%b s_wvalid=%b, expected 0 0", s_awvalid, s_wvalid);
        end
        idle();
        m_bready = '1; s_bvalid = 1; s_bid = 4'h5;
        for (int k = 0; k < 4; k++) begin
            eb = '0;
            eb[k*IW +: IW] = 4'h5;
            #1;
            checks++;
            if (m_bvalid !== N'(1) << k || m_bid !== eb) begin
                errors++; $display("FAIL ot_b[%0d]: m_bvalid=%b m_bid=%h, expected master %0d",
                                   k, m_bvalid, m_bid, k);
            end
            @(posedge clk); #1;
        end
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_concurrent();
        logic [N*DW-1:0] ed;
        m_awvalid = 8'b0001_0000; m_arvalid = 8'b1000_0000; s_awready = 1; s_arready = 1;
        #1;
        checks++;
        if (m_awready !== 8'b0001_0000 || m_arready !== 8'b1000_0000 || !s_awvalid || !s_arvalid) begin
            errors++; $display("FAIL cc_grant: m_awready=%b m_arready=%b, expected 00010000 10000000",
                               m_awready, m_arready);
        end
        @(posedge clk); #1;
        idle();
        m_wvalid = 8'b0001_0000; m_wlast = '1; s_wready = 1; m_wdata[4*DW +: DW] = 24'h444444;
        #1;
        checks++;
        if (m_wready !== 8'b0001_0000 || s_wdata !== 24'h444444) begin
            errors++; $display("FAIL cc_w: m_wready=%b wdata=%h, expected 00010000 444444", m_wready, s_wdata);
        end
        @(posedge clk); #1;
        idle();
        m_bready = '1; m_rready = '1; s_bvalid = 1; s_rvalid = 1; s_rlast = 1; s_rdata = 24'h777777;
        ed = '0;
        ed[7*DW +: DW] = 24'h777777;
        #1;
        checks++;
        if (m_bvalid !== 8'b0001_0000 || m_rvalid !== 8'b1000_0000 || m_rdata !== ed || m_rlast !== 8'b1000_0000) begin
            errors++; $display("FAIL cc_resp: m_bvalid=%b m_rvalid=%b m_rlast=%b, expected b->4 r->7",
                               m_bvalid, m_rvalid, m_rlast);
        end
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int om [2];
        om = '{1, 3};
        m_arvalid = 8'b0000_1010; s_arready = 1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (m_arready !== N'(1) << om[k]) begin
                errors++; $display("FAIL rm_grant[%0d]: m_arready=%b, expected master %0d", k, m_arready, om[k]);
            end
            @(posedge clk); #1;
            m_arvalid[om[k]] = 1'b0;
        end
        s_arready = 0; m_arvalid = 8'b0000_0001; s_rvalid = 1;
        #2;
        rst = 1;
        #1;
        checks++;
        if (s_rready !== 1'b0 || m_rvalid !== '0 || s_arvalid !== 1'b0 || m_arready !== '0) begin
            errors++; $display("FAIL rm_async: s_rready=%b m_rvalid=%b s_arvalid=%b m_arready=%b, expected 0",
                               s_rready, m_rvalid, s_arvalid, m_arready);
        end
        @(posedge clk); #1;
        rst = 0;
        m_arvalid = 8'b0010_0001; s_arready = 1; m_rready = '1;
        #1;
        checks++;
        if (m_arready !== 8'b0000_0001 || s_araddr !== 16'h2000 || s_rready !== 1'b0 || m_rvalid !== '0) begin
            errors++; $display("FAIL rm_after: m_arready=%b araddr=%h s_rready=%b, expected 00000001 2000 0",
                               m_arready, s_araddr, s_rready);
        end
        @(posedge clk); #1;
        idle();
        @(posedge clk); #1;
    endtask

    task automatic test_prio();
        int ex [4];
`ifdef AXI_ARB_PRIO_EN
        ex = '{0, 0, 0, 0};
`else
        ex = '{0, 2, 0, 2};
`endif
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        m_arvalid = 8'b0000_0101; s_arready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (m_arready !== N'(1) << ex[k]) begin
                errors++; $display("FAIL prio_seq[%0d]: m_arready=%b, expected master %0d", k, m_arready, ex[k]);
            end
            @(posedge clk); #1;
        end
        idle();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            m_awaddr[i*AW +: AW] = AW'(16'h1000 + i);
            m_araddr[i*AW +: AW] = AW'(16'h2000 + i);
            m_awid[i*IW +: IW] = IW'(i);
            m_arid[i*IW +: IW] = IW'(i);
        end
        m_awlen = {N{8'd3}}; m_arlen = {N{8'd1}};
        m_awsize = {N{3'd2}}; m_arsize = {N{3'd2}};
        m_awburst = {N{BURST_INCR}}; m_arburst = {N{BURST_INCR}};
        m_wstrb = '1;
        test_reset();
        test_ar_rr();
        test_aw_lock();
        test_ot_limit();
        test_concurrent();
        test_reset_mid();
        test_prio();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end
endmodule
